// File: rtl/rx_port_pkg.sv
// rx_port_pkg: shared widths and FSM state encoding for the RX port channel gate.
package rx_port_pkg;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 32;
   localparam int OFF_W  = 31;
   typedef enum logic [2:0] {IDLE, OPEN, DATA, CLOSE, DONE} state_t;
endpackage

// File: rtl/rx_port_channel_gate_32_if.sv
// rx_port_channel_gate_32_if: descriptor, FIFO, completion and CHNL_RX bundle.
// slave  = the gate (consumes descriptor/FIFO, drives channel and completion)
// master = the surroundings (RX port internals plus user channel)
interface rx_port_channel_gate_32_if;
   import rx_port_pkg::*;
   logic              TXN;
   logic              TXN_ACK;
   logic [LEN_W-1:0]  TXN_LEN;
   logic [OFF_W-1:0]  TXN_OFF;
   logic              TXN_LAST;
   logic [WORD_W-1:0] BUF_DATA;
   logic              BUF_EMPTY;
   logic              BUF_REN;
   logic              ABORT;
   logic              TXN_DONE;
   logic [LEN_W-1:0]  TXN_DONE_LEN;
   logic              TXN_DONE_ERR;
   logic              TXN_DONE_ACK;
   logic              CHNL_RX;
   logic              CHNL_RX_ACK;
   logic              CHNL_RX_LAST;
   logic [LEN_W-1:0]  CHNL_RX_LEN;
   logic [OFF_W-1:0]  CHNL_RX_OFF;
   logic [WORD_W-1:0] CHNL_RX_DATA;
   logic              CHNL_RX_DATA_VALID;
   logic              CHNL_RX_DATA_REN;
   modport slave (
      input  TXN, TXN_LEN, TXN_OFF, TXN_LAST, BUF_DATA, BUF_EMPTY, ABORT,
             TXN_DONE_ACK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
      output TXN_ACK, BUF_REN, TXN_DONE, TXN_DONE_LEN, TXN_DONE_ERR, CHNL_RX,
             CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID
   );
   modport master (
      output TXN, TXN_LEN, TXN_OFF, TXN_LAST, BUF_DATA, BUF_EMPTY, ABORT,
             TXN_DONE_ACK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
      input  TXN_ACK, BUF_REN, TXN_DONE, TXN_DONE_LEN, TXN_DONE_ERR, CHNL_RX,
             CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA, CHNL_RX_DATA_VALID
   );
endinterface

// File: rtl/rx_port_out_reg_32.sv
// rx_port_out_reg_32: single-entry output register between an FWFT FIFO and the channel.
// Ports: CLK/RST_N clock and sync active-low reset; en allows fetching (else valid clears);
// avail FIFO non-empty; room more words may be fetched; ren channel read enable;
// din FIFO head; pop FIFO read strobe; consume beat taken; valid/dout output register.
module rx_port_out_reg_32 #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         en,
   input  logic         avail,
   input  logic         room,
   input  logic         ren,
   input  logic [W-1:0] din,
   output logic         pop,
   output logic         consume,
   output logic         valid,
   output logic [W-1:0] dout
);
   assign consume = valid && ren;
   // refill when empty or when the held word leaves this same cycle
   assign pop = en && avail && room && (!valid || ren);
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid <= 1'b0;
         dout  <= '0;
      end else begin
         valid <= en && (pop || (valid && !ren));
         if (pop) dout <= din;
      end
   end
endmodule

// File: rtl/rx_port_channel_gate_32.sv
// rx_port_channel_gate_32: RX port channel end; opens CHNL_RX, streams LEN words, reports completion.
// Ports: CLK port clock; RST_N sync active-low reset; io (slave) carries the descriptor
// (TXN/TXN_ACK/LEN/OFF/LAST), FIFO head (BUF_*), ABORT, completion (TXN_DONE*) and CHNL_RX_*.
module rx_port_channel_gate_32
   import rx_port_pkg::*;
#(
   parameter int C_DATA_WIDTH = WORD_W,
   parameter int C_LEN_WIDTH  = LEN_W
) (
   input logic                    CLK,
   input logic                    RST_N,
   rx_port_channel_gate_32_if.slave io
);
   state_t                  state, state_nx;
   logic [C_LEN_WIDTH-1:0]  len, fetched, sent;
   logic [OFF_W-1:0]        off;
   logic                    last, err, txn_ack, cap, in_data, pop, consume, valid;
   logic [C_DATA_WIDTH-1:0] data;

   assign cap     = state == IDLE && io.TXN;
   assign in_data = state == DATA;

   rx_port_out_reg_32 #(.W(C_DATA_WIDTH)) u_out (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .en      (in_data && !io.ABORT),
      .avail   (!io.BUF_EMPTY),
      .room    (fetched < len),
      .ren     (io.CHNL_RX_DATA_REN),
      .din     (io.BUF_DATA),
      .pop     (pop),
      .consume (consume),
      .valid   (valid),
      .dout    (data)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = io.TXN ? OPEN : IDLE;
         OPEN:    state_nx = io.ABORT ? CLOSE : !io.CHNL_RX_ACK ? OPEN : (len == '0) ? CLOSE : DATA;
         // sent < len here, so sent+1 cannot wrap even for LEN = all ones
         DATA:    state_nx = (io.ABORT || (consume && sent + 1'b1 == len)) ? CLOSE : DATA;
         CLOSE:   state_nx = DONE;
         DONE:    state_nx = io.TXN_DONE_ACK ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= IDLE;
         txn_ack <= 1'b0;
         len     <= '0;
         off     <= '0;
         last    <= 1'b0;
         err     <= 1'b0;
         fetched <= '0;
         sent    <= '0;
      end else begin
         state   <= state_nx;
         txn_ack <= cap;
         if (cap) begin
            len     <= io.TXN_LEN;
            off     <= io.TXN_OFF;
            last    <= io.TXN_LAST;
            err     <= 1'b0;
            fetched <= '0;
            sent    <= '0;
         end
         if (pop) fetched <= fetched + 1'b1;
         if (in_data && consume) sent <= sent + 1'b1;
         if ((state == OPEN || in_data) && io.ABORT) err <= 1'b1;
      end
   end

   assign io.TXN_ACK            = txn_ack;
   assign io.BUF_REN            = pop;
   assign io.TXN_DONE           = state == DONE;
   assign io.TXN_DONE_LEN       = sent;
   assign io.TXN_DONE_ERR       = err;
   assign io.CHNL_RX            = state == OPEN || in_data;
   assign io.CHNL_RX_LAST       = last;
   assign io.CHNL_RX_LEN        = len;
   assign io.CHNL_RX_OFF        = off;
   assign io.CHNL_RX_DATA       = data;
   assign io.CHNL_RX_DATA_VALID = valid;
endmodule

// File: tb/tb_rx_port_channel_gate_32.sv
// tb_rx_port_channel_gate_32: randomized self-checking bench with a queue-based FIFO and word-order model.
module tb_rx_port_channel_gate_32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rx_port_channel_gate_32_if bus();
   rx_port_channel_gate_32 dut (.CLK(clk), .RST_N(rst_n), .io(bus));

   int checks = 0;
   int failures = 0;
   logic [31:0] fifo[$];
   logic [31:0] src[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_flags"}, {bus.TXN_ACK, bus.BUF_REN, bus.TXN_DONE, bus.TXN_DONE_ERR,
                              bus.CHNL_RX, bus.CHNL_RX_LAST, bus.CHNL_RX_DATA_VALID}, 0);
      check({tag, "_len"}, bus.CHNL_RX_LEN, 0);
      check({tag, "_off"}, bus.CHNL_RX_OFF, 0);
      check({tag, "_data"}, bus.CHNL_RX_DATA, 0);
      check({tag, "_done_len"}, bus.TXN_DONE_LEN, 0);
   endtask

   task automatic preload(input int n, input bit seq);
      logic [31:0] w;
      fifo.delete();
      src.delete();
      for (int i = 0; i < n; i++) begin
         w = seq ? 32'hA0 + 32'(i) : $urandom;
         fifo.push_back(w);
         src.push_back(w);
      end
   endtask

   task automatic feed(input bit gap);
      bus.BUF_EMPTY = gap || fifo.size() == 0;
      bus.BUF_DATA  = fifo.size() != 0 ? fifo[0] : 32'h0;
   endtask

   task automatic run(input string nm, input logic [31:0] len, input logic [30:0] off, input logic last,
                      input int ack_dly, input int ren_pct, input bit gaps, input int abort_at,
                      input int rst_at, input logic [31:0] exp_len, input logic exp_err,
                      input int exp_pops, input bit b2b);
      int pops = 0, beats = 0, cyc = 0, bad_pops = 0, post_abort = 0, valid_cyc = 0;
      int first_cyc = -1, last_cyc = -1, dones = 0;
      bit aborted = 0, prev_pop = 0, fall_next = 0, gap;
      int left;
      left = fifo.size() - exp_pops;
      @(negedge clk);
      bus.TXN = 1'b1; bus.TXN_LEN = len; bus.TXN_OFF = off; bus.TXN_LAST = last;
      feed(1'b0);
      @(negedge clk);
      bus.TXN = 1'b0;
      check({nm, "_txn_ack"}, bus.TXN_ACK, 1);
      check({nm, "_rx_rise"}, bus.CHNL_RX, 1);
      check({nm, "_rx_len"}, bus.CHNL_RX_LEN, len);
      check({nm, "_rx_off"}, bus.CHNL_RX_OFF, off);
      check({nm, "_rx_last"}, bus.CHNL_RX_LAST, last);
      while (cyc < 3000) begin
         if (bus.TXN_DONE) break;
         if (cyc == 1) check({nm, "_ack_pulse"}, bus.TXN_ACK, 0);
         if (fall_next) begin
            check({nm, "_rx_fall"}, {bus.CHNL_RX, bus.CHNL_RX_DATA_VALID}, 0);
            fall_next = 0;
         end
         bus.CHNL_RX_ACK = bus.CHNL_RX && cyc >= ack_dly;
         bus.CHNL_RX_DATA_REN = $urandom_range(99) < ren_pct;
         bus.ABORT = 1'b0;
         gap = gaps && (cyc % 10) >= 5;
         if (abort_at >= 0 && !aborted && beats == abort_at) begin
            bus.ABORT = 1'b1;
            bus.CHNL_RX_DATA_REN = 1'b1;
            aborted = 1;
         end
         if (rst_at >= 0 && beats == rst_at && bus.CHNL_RX_DATA_VALID) begin
            rst_n = 1'b0;
            bus.CHNL_RX_DATA_REN = 1'b0;
            feed(1'b1);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            check_zero({nm, "_rst"});
            repeat (5) begin
               @(negedge clk);
               dones += int'(bus.TXN_DONE);
            end
            check({nm, "_no_done"}, dones, 0);
            bus.CHNL_RX_ACK = 1'b0;
            bus.CHNL_RX_DATA_REN = 1'b0;
            return;
         end
         feed(gap);
         #1;
         if (prev_pop) check({nm, "_valid_lat"}, bus.CHNL_RX_DATA_VALID, 1);
         valid_cyc += int'(bus.CHNL_RX_DATA_VALID);
         prev_pop = bus.BUF_REN;
         if (bus.BUF_REN) begin
            pops++;
            if (bus.BUF_EMPTY) bad_pops++;
            if (aborted) post_abort++;
            if (fifo.size() != 0) void'(fifo.pop_front());
         end
         if (bus.CHNL_RX_DATA_VALID && bus.CHNL_RX_DATA_REN) begin
            check($sformatf("%s_beat%0d", nm, beats), bus.CHNL_RX_DATA,
                  beats < src.size() ? src[beats] : 32'hDEAD_BEEF);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
            fall_next = !aborted && beats == int'(len);
         end
         @(negedge clk);
         cyc++;
      end
      check({nm, "_done_seen"}, bus.TXN_DONE, 1);
      check({nm, "_done_len"}, bus.TXN_DONE_LEN, exp_len);
      check({nm, "_done_err"}, bus.TXN_DONE_ERR, exp_err);
      check({nm, "_beats"}, beats, exp_len);
      check({nm, "_close_idle"}, {bus.CHNL_RX, bus.CHNL_RX_DATA_VALID}, 0);
      check({nm, "_pops"}, pops, exp_pops);
      check({nm, "_bad_pops"}, bad_pops, 0);
      check({nm, "_fifo_left"}, fifo.size(), left);
      if (abort_at >= 0) check({nm, "_post_abort_pops"}, post_abort, 0);
      if (len == 0) check({nm, "_no_valid"}, valid_cyc, 0);
      if (b2b) check({nm, "_b2b_span"}, last_cyc - first_cyc, int'(len) - 1);
      bus.CHNL_RX_ACK = 1'b0;
      bus.CHNL_RX_DATA_REN = 1'b0;
      bus.TXN_DONE_ACK = 1'b1;
      @(negedge clk);
      bus.TXN_DONE_ACK = 1'b0;
      check({nm, "_done_clr"}, bus.TXN_DONE, 0);
   endtask

   initial begin
      int n, l;
      bus.TXN = 0; bus.TXN_LEN = 0; bus.TXN_OFF = 0; bus.TXN_LAST = 0;
      bus.BUF_DATA = 0; bus.BUF_EMPTY = 1; bus.ABORT = 0; bus.TXN_DONE_ACK = 0;
      bus.CHNL_RX_ACK = 0; bus.CHNL_RX_DATA_REN = 0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      bus.ABORT = 1'b1;
      @(negedge clk);
      bus.ABORT = 1'b0;
      check({"idle_abort"}, {bus.TXN_DONE, bus.CHNL_RX}, 0);

      preload(4, 1);
      run("normal", 4, 31'h10, 1, 3, 100, 0, -1, -1, 4, 0, 4, 1);
      preload(3, 0);
      run("zero", 0, 31'h5, 0, 2, 100, 0, -1, -1, 0, 0, 0, 0);
      preload(8, 0);
      run("bp", 8, 31'($urandom), 1'($urandom), 1, 50, 1, -1, -1, 8, 0, 8, 0);
      preload(10, 0);
      run("overfull", 6, 31'h77, 0, 0, 100, 0, -1, -1, 6, 0, 6, 0);
      preload(16, 0);
      run("abort", 16, 31'h200, 1, 1, 100, 0, 5, -1, 6, 1, 6, 0);
      preload(8, 0);
      run("rstmid", 8, 31'h33, 1, 1, 100, 0, -1, 3, 0, 0, 0, 0);
      preload(2, 0);
      run("after_rst", 2, 31'h44, 0, 1, 100, 0, -1, -1, 2, 0, 2, 1);
      for (int i = 0; i < 4; i++) begin
         l = $urandom_range(12, 1);
         n = l + $urandom_range(3);
         preload(n, 0);
         run($sformatf("rnd%0d", i), 32'(l), 31'($urandom), 1'($urandom), $urandom_range(4),
             70, 1'($urandom), -1, -1, 32'(l), 0, l, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
